// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - execute-stage ALU with iterative 1-bit-per-cycle shifter
module alu_seq_exec #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_code,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   acc;
  logic [SHAMT_W-1:0]  cnt;
  logic [1:0]          shift_kind;

  logic [DATA_W-1:0]   fast_res;
  logic                fast_ill;
  logic                is_shift;
  logic [DATA_W-1:0]   acc_next;

  assign is_shift = (alu_code[3:2] == 2'b00) && (alu_code[1:0] != 2'b11);

  // Single-cycle results; a shift by zero simply passes op_b through.
  always_comb begin
    fast_res = '0;
    fast_ill = 1'b0;
    case (alu_code)
      4'b0000, 4'b0001, 4'b0010: fast_res = op_b;
      4'b0011: fast_res = op_a + op_b;
      4'b0100: fast_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0101: fast_res = op_a & op_b;
      4'b0110: fast_res = op_a | op_b;
      4'b0111: fast_res = op_a ^ op_b;
      4'b1000: fast_res = ~(op_a | op_b);
      4'b1001: fast_res = {op_b[15:0], {(DATA_W-16){1'b0}}};
      4'b1010: fast_res = op_a - op_b;
      default: fast_ill = 1'b1;
    endcase
  end

  always_comb begin
    acc_next = acc;
    case (shift_kind)
      2'b00:   acc_next = {acc[DATA_W-2:0], 1'b0};
      2'b01:   acc_next = {1'b0, acc[DATA_W-1:1]};
      default: acc_next = {acc[DATA_W-1], acc[DATA_W-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b1;
      illegal    <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      shift_kind <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_shift && (shamt != '0)) begin
              acc        <= op_b;
              cnt        <= shamt;
              shift_kind <= alu_code[1:0];
              state      <= S_SHIFT;
            end else begin
              result    <= fast_res;
              zero      <= (fast_res == '0);
              illegal   <= fast_ill;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            result    <= acc_next;
            zero      <= (acc_next == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // No accept here: ready only returns once the result has left.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - self-checking bench for alu_seq_exec
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_code = 4'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  alu_seq_exec #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_code(alu_code), .op_a(op_a), .op_b(op_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what an op must produce, from plain operators.
  function automatic logic [32:0] model_eval(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] s);
    logic [31:0] r;
    logic        ill;
    ill = 1'b0;
    case (c)
      4'd0:  r = b << s;
      4'd1:  r = b >> s;
      4'd2:  r = $unsigned($signed(b) >>> s);
      4'd3:  r = a + b;
      4'd4:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd8:  r = ~(a | b);
      4'd9:  r = b << 16;
      4'd10: r = a - b;
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    return {ill, r};
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [4:0] s);
    return (c <= 4'd2 && s != 0) ? int'(s) + 1 : 1;
  endfunction

  // Transaction-level model: one pending op, completes at a known cycle.
  int          cyc = 0;
  bit          m_pending = 0;
  int          m_due = 0;
  logic [31:0] m_res = '0;
  logic        m_ill = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [32:0] ev;
    if (!rst_n) begin
      m_pending = 0;
    end else begin
      cyc++;
      if (!m_pending) begin
        if (in_valid) begin
          ev = model_eval(alu_code, op_a, op_b, shamt);
          m_res = ev[31:0];
          m_ill = ev[32];
          m_due = cyc + model_lat(alu_code, shamt) - 1;
          m_pending = 1;
        end
      end else if (cyc > m_due && out_ready) begin
        m_pending = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit ev_valid;
    if (rst_n) begin
      ev_valid = m_pending && (cyc >= m_due);
      chk("cmp_out_valid", {31'd0, out_valid}, {31'd0, ev_valid});
      chk("cmp_in_ready", {31'd0, in_ready}, {31'd0, !m_pending});
      if (ev_valid) begin
        chk("cmp_result", result, m_res);
        chk("cmp_zero", {31'd0, zero}, {31'd0, (m_res == 32'd0)});
        chk("cmp_illegal", {31'd0, illegal}, {31'd0, m_ill});
      end
    end
  end

  task automatic do_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s,
                       input logic [31:0] exp_res, input int exp_lat,
                       input logic exp_ill, input int hold);
    int lat;
    int bound;
    @(negedge clk);
    alu_code = c; op_a = a; op_b = b; shamt = s;
    out_ready = (hold == 0);
    in_valid = 1'b1;
    bound = 0;
    while (!in_ready && bound < 100) begin @(negedge clk); bound++; end
    chk({nm, "_accept_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    alu_code = 4'($urandom); op_a = $urandom; op_b = $urandom; shamt = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_result"}, result, exp_res);
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    chk({nm, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk({nm, "_held_result"}, result, exp_res);
        chk({nm, "_held_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_release_in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({nm, "_release_out_valid"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    do_op("add_wrap", 4'b0011, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1, 1'b0, 0);
    do_op("sub_neg",  4'b1010, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1, 1'b0, 0);
    do_op("slt_t",    4'b0100, 32'h80000000, 32'd1, 5'd0, 32'd1, 1, 1'b0, 0);
    do_op("slt_f",    4'b0100, 32'd1, 32'h80000000, 5'd0, 32'd0, 1, 1'b0, 0);
    do_op("sra4",     4'b0010, 32'd0, 32'h80000010, 5'd4, 32'hF8000001, 5, 1'b0, 0);
    do_op("sll0",     4'b0000, 32'd0, 32'h00001234, 5'd0, 32'h00001234, 1, 1'b0, 0);
    do_op("srl31",    4'b0001, 32'd0, 32'h80000000, 5'd31, 32'd1, 32, 1'b0, 0);
    do_op("sll3",     4'b0000, 32'd0, 32'd1, 5'd3, 32'd8, 4, 1'b0, 0);
    do_op("sra_pos",  4'b0010, 32'd0, 32'h40000000, 5'd2, 32'h10000000, 3, 1'b0, 0);
    do_op("and",      4'b0101, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'h00F0000F, 1, 1'b0, 0);
    do_op("or",       4'b0110, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'hFFF00FFF, 1, 1'b0, 0);
    do_op("xor",      4'b0111, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'hFF000FF0, 1, 1'b0, 0);
    do_op("nor",      4'b1000, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'h000FF000, 1, 1'b0, 0);
    do_op("lui_bp",   4'b1001, 32'd0, 32'h0000ABCD, 5'd0, 32'hABCD0000, 1, 1'b0, 6);
    do_op("illegal",  4'b1101, 32'h12345678, 32'h9ABCDEF0, 5'd0, 32'd0, 1, 1'b1, 0);

    // Abort a long shift with an asynchronous reset pulse.
    @(negedge clk);
    alu_code = 4'b0000; op_a = '0; op_b = 32'h00000001; shamt = 5'd20;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);

    do_op("post_abort", 4'b0011, 32'd2, 32'd3, 5'd0, 32'd5, 1, 1'b0, 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
